// File: rtl/matrix_write_arbiter.sv
// Single write-port arbiter for the 32x32 frame RAM: host pixel stream vs. full-frame fill,
// each write sequenced IDLE -> SETUP -> STROBE so address/data settle before we rises.
module matrix_write_arbiter #(
  parameter int N = 10,
  parameter int M = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         host_valid,
  output logic         host_ready,
  input  logic [N-1:0] host_adr,
  input  logic [M-1:0] host_rgb,
  input  logic         fill_start,
  input  logic [M-1:0] fill_rgb,
  output logic         fill_busy,
  output logic         fill_done,
  output logic         we,
  output logic [N-1:0] adr_out,
  output logic [M-1:0] rgb_out
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE} state_t;

  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] LAST_ADR = {N{1'b1}};

  state_t       state_q, state_d;
  logic         we_q, we_d;
  logic [N-1:0] adr_q, adr_d;
  logic [M-1:0] rgb_q, rgb_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [M-1:0] col_q, col_d;
  logic         last_host_q, last_host_d;
  logic         wr_fill_q, wr_fill_d;
  logic         host_gnt, fill_gnt;

  // After a host grant, the host must yield to a pending fill before winning again.
  assign host_ready = (state_q == IDLE) && !(busy_q && last_host_q) && !reset;
  assign host_gnt   = host_valid && host_ready;
  assign fill_gnt   = (state_q == IDLE) && busy_q && !host_gnt;

  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    adr_d       = adr_q;
    rgb_d       = rgb_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    col_d       = col_q;
    last_host_d = last_host_q;
    wr_fill_d   = wr_fill_q;

    case (state_q)
      IDLE: begin
        if (host_gnt) begin
          adr_d       = host_adr;
          rgb_d       = host_rgb;
          last_host_d = 1'b1;
          wr_fill_d   = 1'b0;
          state_d     = SETUP;
        end else if (fill_gnt) begin
          adr_d       = cnt_q;
          rgb_d       = col_q;
          cnt_d       = cnt_q + ONE;
          last_host_d = 1'b0;
          wr_fill_d   = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        we_d    = 1'b1;
        state_d = STROBE;
      end
      STROBE: begin
        state_d = IDLE;
        if (wr_fill_q && (adr_q == LAST_ADR)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A start while busy is ignored; the done cycle already has busy low, so it restarts.
    if (fill_start && !busy_q) begin
      busy_d = 1'b1;
      col_d  = fill_rgb;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      adr_q       <= '0;
      rgb_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
      col_q       <= '0;
      last_host_q <= 1'b0;
      wr_fill_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      rgb_q       <= rgb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      last_host_q <= last_host_d;
      wr_fill_q   <= wr_fill_d;
    end
  end

  assign we        = we_q;
  assign adr_out   = adr_q;
  assign rgb_out   = rgb_q;
  assign fill_busy = busy_q;
  assign fill_done = done_q;

endmodule

// File: tb/tb_matrix_write_arbiter.sv
// Self-checking bench for matrix_write_arbiter: slot-countdown reference model compared every
// cycle, a RAM captured from the DUT strobe, and hand-computed expectations for the key scenarios.
module tb_matrix_write_arbiter;
  localparam int N = 10;
  localparam int M = 3;
  localparam int DEPTH = 1 << N;

  logic         clk = 1'b0;
  logic         reset;
  logic         host_valid;
  logic         host_ready;
  logic [N-1:0] host_adr;
  logic [M-1:0] host_rgb;
  logic         fill_start;
  logic [M-1:0] fill_rgb;
  logic         fill_busy;
  logic         fill_done;
  logic         we;
  logic [N-1:0] adr_out;
  logic [M-1:0] rgb_out;

  matrix_write_arbiter #(.N(N), .M(M)) dut (
    .clk(clk), .reset(reset),
    .host_valid(host_valid), .host_ready(host_ready), .host_adr(host_adr), .host_rgb(host_rgb),
    .fill_start(fill_start), .fill_rgb(fill_rgb), .fill_busy(fill_busy), .fill_done(fill_done),
    .we(we), .adr_out(adr_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // RAM as seen from the DUT write port, plus a log of every strobe.
  logic [M-1:0]   ram [DEPTH];
  logic [N+M-1:0] wlog[$];
  int busy_cycles = 0;
  int done_cnt = 0;

  always @(posedge we) begin
    ram[adr_out] <= rgb_out;
    wlog.push_back({adr_out, rgb_out});
  end

  always @(negedge clk) begin
    if (fill_busy === 1'b1) busy_cycles <= busy_cycles + 1;
    if (fill_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  // Reference model: the port is a resource held for 3 cycles per write (m_left counts down);
  // the fill is a colour plus the next address to paint; fairness is "who went last".
  bit           m_busy, m_last_host, m_cur_fill, m_done;
  int           m_left, m_cnt;
  logic [N-1:0] m_adr;
  logic [M-1:0] m_rgb, m_col;
  logic [M-1:0] m_ram [DEPTH];
  logic         m_ready, m_hgo, m_fgo;

  assign m_ready = (m_left == 0) && !(m_busy && m_last_host);
  assign m_hgo   = host_valid && m_ready;
  assign m_fgo   = (m_left == 0) && m_busy && !m_hgo;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0; m_last_host <= 0; m_cur_fill <= 0; m_done <= 0;
      m_left <= 0; m_cnt <= 0; m_adr <= '0; m_rgb <= '0;
    end else begin
      m_done <= 0;
      if (m_left == 2) m_ram[m_adr] <= m_rgb;
      m_left <= (m_left > 0) ? m_left - 1 : 0;
      if (m_left == 1 && m_cur_fill && m_adr == N'(DEPTH - 1)) begin
        m_busy <= 0;
        m_done <= 1;
      end
      if (fill_start && !m_busy) begin
        m_busy <= 1;
        m_col  <= fill_rgb;
        m_cnt  <= 0;
      end
      if (m_hgo) begin
        m_adr <= host_adr; m_rgb <= host_rgb; m_left <= 2;
        m_last_host <= 1; m_cur_fill <= 0;
      end else if (m_fgo) begin
        m_adr <= N'(m_cnt); m_rgb <= m_col; m_cnt <= (m_cnt + 1) % DEPTH; m_left <= 2;
        m_last_host <= 0; m_cur_fill <= 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [16:0] a, e;
    @(negedge clk);
    #1;
    if (cmp_en) begin
      a = {we, adr_out, rgb_out, host_ready, fill_busy, fill_done};
      e = {(m_left == 1), m_adr, m_rgb, (m_ready && !reset), m_busy, m_done};
      check("outputs{we,adr,rgb,ready,busy,done}", 32'(a), 32'(e));
    end
  endtask

  task automatic run_until_done(input int d0, input int limit);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      tick();
      n++;
    end
    check("fill_done_within_budget", 32'(done_cnt != d0), 32'd1);
  endtask

  int b0, d0, l0, bad, nh, n2, n1;
  logic [N+M-1:0] ent;

  initial begin
    reset = 1; host_valid = 0; host_adr = '0; host_rgb = '0; fill_start = 0; fill_rgb = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_we", 32'(we), 0);
    check("rst_adr", 32'(adr_out), 0);
    check("rst_ready", 32'(host_ready), 0);
    check("rst_busy", 32'(fill_busy), 0);
    cmp_en = 1;
    reset = 0;
    tick();
    check("idle_ready", 32'(host_ready), 1);

    // single host write
    host_valid = 1; host_adr = 10'h025; host_rgb = 3'b101;
    tick();
    host_valid = 0;
    check("setup_adr", 32'(adr_out), 32'h025);
    check("setup_rgb", 32'(rgb_out), 5);
    check("setup_we", 32'(we), 0);
    tick();
    check("strobe_we", 32'(we), 1);
    tick();
    check("post_strobe_we", 32'(we), 0);
    check("ram_025", 32'(ram[10'h025]), 5);

    // fill alone
    b0 = busy_cycles; d0 = done_cnt; l0 = wlog.size();
    fill_rgb = 3'b010; fill_start = 1;
    tick();
    fill_start = 0;
    run_until_done(d0, 4000);
    repeat (4) tick();
    check("fill_busy_cycles", 32'(busy_cycles - b0), 3072);
    check("fill_done_pulses", 32'(done_cnt - d0), 1);
    check("fill_write_count", 32'(wlog.size() - l0), 1024);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ent = wlog[l0 + i];
      if (ent !== {N'(i), 3'd2}) bad++;
      if (ram[i] !== 3'd2) bad++;
    end
    check("fill_order_and_ram", 32'(bad), 0);

    // fill under continuous host traffic, with an ignored restart mid-way
    d0 = done_cnt; l0 = wlog.size();
    fill_rgb = 3'b010; fill_start = 1;
    host_valid = 1; host_adr = 10'h3FF; host_rgb = 3'd7;
    tick();
    fill_start = 0;
    repeat (1500) tick();
    fill_rgb = 3'b001; fill_start = 1;
    tick();
    fill_start = 0;
    run_until_done(d0, 8000);
    repeat (6) tick();
    host_valid = 0;
    repeat (4) tick();
    nh = 0; n2 = 0; n1 = 0;
    for (int i = l0; i < wlog.size(); i++) begin
      ent = wlog[i];
      if (ent[M-1:0] == 3'd7) nh++;
      if (ent[M-1:0] == 3'd2) n2++;
      if (ent[M-1:0] == 3'd1) n1++;
    end
    check("contended_fill_writes", 32'(n2), 1024);
    check("restart_colour_unused", 32'(n1), 0);
    check("contended_host_writes_ge_1024", 32'(nh >= 1024), 1);
    check("contended_single_done", 32'(done_cnt - d0), 1);
    bad = 0;
    for (int i = 0; i < DEPTH - 1; i++) if (ram[i] !== 3'd2) bad++;
    check("contended_ram", 32'(bad), 0);
    check("ram_3ff_last_host", 32'(ram[10'h3FF]), 7);

    // reset during the strobe of fill address 500
    fill_rgb = 3'd3; fill_start = 1;
    tick();
    fill_start = 0;
    begin
      int n = 0;
      while (!(m_left == 1 && m_cur_fill && m_adr == 10'd500) && n < 3000) begin
        tick();
        n++;
      end
      check("reach_adr_500", 32'(n < 3000), 1);
    end
    #1 reset = 1;
    #1;
    check("mid_reset_we", 32'(we), 0);
    check("mid_reset_busy", 32'(fill_busy), 0);
    check("mid_reset_ready", 32'(host_ready), 0);
    d0 = done_cnt;
    tick();
    tick();
    reset = 0;
    repeat (10) tick();
    check("no_done_after_cancel", 32'(done_cnt - d0), 0);
    check("ram_500_written", 32'(ram[500]), 3);
    check("ram_501_old", 32'(ram[501]), 2);

    host_valid = 1; host_adr = 10'h123; host_rgb = 3'd6;
    tick();
    host_valid = 0;
    repeat (4) tick();
    check("host_after_reset", 32'(ram[10'h123]), 6);

    // simultaneous host request and fill start
    l0 = wlog.size(); d0 = done_cnt;
    host_valid = 1; host_adr = 10'h100; host_rgb = 3'd5;
    fill_start = 1; fill_rgb = 3'd4;
    tick();
    host_valid = 0; fill_start = 0;
    run_until_done(d0, 4000);
    repeat (3) tick();
    ent = wlog[l0];
    check("simul_first_host", 32'(ent), 32'({10'h100, 3'd5}));
    ent = wlog[l0 + 1];
    check("simul_then_fill_adr0", 32'(ent), 32'({10'h000, 3'd4}));
    check("simul_write_count", 32'(wlog.size() - l0), 1025);
    check("ram_100_refilled", 32'(ram[10'h100]), 4);
    check("ram_501_refilled", 32'(ram[501]), 4);

    // randomized traffic
    for (int c = 0; c < 6000; c++) begin
      host_valid = 1'($urandom_range(0, 1));
      host_adr   = N'($urandom);
      host_rgb   = M'($urandom);
      fill_start = ($urandom_range(0, 299) == 0);
      fill_rgb   = M'($urandom);
      tick();
    end
    host_valid = 0; fill_start = 0;
    begin
      int n = 0;
      while (fill_busy !== 1'b0 && n < 8000) begin
        tick();
        n++;
      end
      check("random_drain", 32'(n < 8000), 1);
    end
    repeat (5) tick();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== m_ram[i]) bad++;
    check("final_ram_vs_model", 32'(bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
